// File: rtl/keccak_absorb_ctrl_if.sv
// Host, shift-register and permutation-core signals of the Keccak absorb sequencer.
// slave = sequencer side, master = host/core/testbench side.
interface keccak_absorb_ctrl_if #(
  parameter int IN_BUF_SIZE = 32,
  parameter int ROUND_W     = 5
);
  logic [IN_BUF_SIZE-1:0] in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [IN_BUF_SIZE-1:0] buf_input;
  logic                   buf_input_valid;
  logic                   perm_absorb;
  logic                   perm_round_en;
  logic [ROUND_W-1:0]     round_num;
  logic                   state_clear;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, buf_input, buf_input_valid, perm_absorb, perm_round_en,
           round_num, state_clear, out_valid, busy
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, buf_input, buf_input_valid, perm_absorb, perm_round_en,
           round_num, state_clear, out_valid, busy
  );
endinterface

// File: rtl/keccak_absorb_ctrl.sv
// Packs host words into rate blocks, appends pad10*1, then sequences one XOR plus NUM_ROUNDS rounds per block.
// Pad/XOR/rounds follow the block's last word back-to-back; host is stalled outside ABSORB, digest held until out_ready.
module keccak_absorb_ctrl #(
  parameter int IN_BUF_SIZE = 32,
  parameter int RATE_WORDS  = 34,
  parameter int NUM_ROUNDS  = 24,
  parameter int ROUND_W     = 5
) (
  input logic           clock,
  input logic           reset,
  keccak_absorb_ctrl_if.slave bus
);

  localparam int WCNT_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [WCNT_W-1:0]      WLAST     = WCNT_W'(RATE_WORDS - 1);
  localparam logic [ROUND_W-1:0]     RLAST     = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [IN_BUF_SIZE-1:0] PAD_FIRST = IN_BUF_SIZE'(1);
  localparam logic [IN_BUF_SIZE-1:0] PAD_LAST  = {1'b1, {(IN_BUF_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {S_ABSORB, S_PAD, S_XOR, S_ROUND, S_SQUEEZE} state_e;

  state_e             state_q;
  logic [WCNT_W-1:0]  wcnt_q;
  logic [ROUND_W-1:0] rcnt_q;
  logic               last_flag_q;
  logic               pad_pending_q;
  logic               pad_first_q;
  logic [IN_BUF_SIZE-1:0] pad_word;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_ABSORB;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      last_flag_q   <= 1'b0;
      pad_pending_q <= 1'b0;
      pad_first_q   <= 1'b0;
    end else begin
      case (state_q)
        S_ABSORB: begin
          if (bus.in_valid) begin
            if (wcnt_q == WLAST) begin
              wcnt_q  <= '0;
              state_q <= S_XOR;
              // Message ends exactly on a block boundary: a whole pad block follows this permutation.
              if (bus.in_last) begin
                pad_pending_q <= 1'b1;
                last_flag_q   <= 1'b0;
              end
            end else begin
              wcnt_q <= wcnt_q + WCNT_W'(1);
              if (bus.in_last) begin
                state_q     <= S_PAD;
                last_flag_q <= 1'b1;
                pad_first_q <= 1'b1;
              end
            end
          end
        end
        S_PAD: begin
          pad_first_q <= 1'b0;
          if (wcnt_q == WLAST) begin
            wcnt_q  <= '0;
            state_q <= S_XOR;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        S_XOR: begin
          rcnt_q  <= '0;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (rcnt_q == RLAST) begin
            rcnt_q <= '0;
            if (last_flag_q) begin
              state_q <= S_SQUEEZE;
            end else if (pad_pending_q) begin
              state_q       <= S_PAD;
              last_flag_q   <= 1'b1;
              pad_pending_q <= 1'b0;
              pad_first_q   <= 1'b1;
            end else begin
              state_q <= S_ABSORB;
            end
          end else begin
            rcnt_q <= rcnt_q + ROUND_W'(1);
          end
        end
        S_SQUEEZE: begin
          if (bus.out_ready) begin
            last_flag_q <= 1'b0;
            state_q     <= S_ABSORB;
          end
        end
        default: state_q <= S_ABSORB;
      endcase
    end
  end

  assign pad_word = (pad_first_q ? PAD_FIRST : '0) | ((wcnt_q == WLAST) ? PAD_LAST : '0);

  logic                   in_ready;
  logic                   bvld;
  logic [IN_BUF_SIZE-1:0] bdat;
  logic                   absorb;
  logic                   round_en;
  logic [ROUND_W-1:0]     round_num;
  logic                   out_valid;
  logic                   clear;
  logic                   busy;

  // Everything is forced low while reset is asserted, including the host handshake.
  always_comb begin
    in_ready  = 1'b0;
    bvld      = 1'b0;
    bdat      = '0;
    absorb    = 1'b0;
    round_en  = 1'b0;
    round_num = '0;
    out_valid = 1'b0;
    clear     = 1'b0;
    busy      = 1'b0;
    if (reset) begin
      busy = !((state_q == S_ABSORB) && (wcnt_q == '0));
      case (state_q)
        S_ABSORB: begin
          in_ready = 1'b1;
          if (bus.in_valid) begin
            bvld = 1'b1;
            bdat = bus.in_data;
          end
        end
        S_PAD: begin
          bvld = 1'b1;
          bdat = pad_word;
        end
        S_XOR:   absorb = 1'b1;
        S_ROUND: begin
          round_en  = 1'b1;
          round_num = rcnt_q;
        end
        S_SQUEEZE: begin
          out_valid = 1'b1;
          clear     = bus.out_ready;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.buf_input_valid = bvld;
  assign bus.buf_input       = bdat;
  assign bus.perm_absorb     = absorb;
  assign bus.perm_round_en   = round_en;
  assign bus.round_num       = round_num;
  assign bus.out_valid       = out_valid;
  assign bus.state_clear     = clear;
  assign bus.busy            = busy;

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Drives a small (4-word rate, 3 rounds) and a default-parameter sequencer against a message-level schedule model.
module tb_keccak_absorb_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        sel        = 1'b0;
  logic [31:0] drv_data   = '0;
  logic        drv_valid  = 1'b0;
  logic        drv_last   = 1'b0;
  logic        drv_oready = 1'b0;

  keccak_absorb_ctrl_if #(.IN_BUF_SIZE(32), .ROUND_W(5)) bs ();
  keccak_absorb_ctrl_if #(.IN_BUF_SIZE(32), .ROUND_W(5)) bd ();

  assign bs.in_data   = drv_data;
  assign bs.in_valid  = drv_valid & ~sel;
  assign bs.in_last   = drv_last;
  assign bs.out_ready = drv_oready & ~sel;
  assign bd.in_data   = drv_data;
  assign bd.in_valid  = drv_valid & sel;
  assign bd.in_last   = drv_last;
  assign bd.out_ready = drv_oready & sel;

  keccak_absorb_ctrl #(.IN_BUF_SIZE(32), .RATE_WORDS(4), .NUM_ROUNDS(3), .ROUND_W(5)) u_small (
    .clock (clock),
    .reset (reset),
    .bus   (bs.slave)
  );

  keccak_absorb_ctrl u_dflt (
    .clock (clock),
    .reset (reset),
    .bus   (bd.slave)
  );

  logic [43:0] obs_s, obs_d, obs;
  assign obs_s = {bs.in_ready, bs.buf_input_valid, bs.buf_input, bs.perm_absorb, bs.perm_round_en,
                  bs.round_num, bs.out_valid, bs.state_clear, bs.busy};
  assign obs_d = {bd.in_ready, bd.buf_input_valid, bd.buf_input, bd.perm_absorb, bd.perm_round_en,
                  bd.round_num, bd.out_valid, bd.state_clear, bd.busy};
  assign obs = sel ? obs_d : obs_s;

  int tests = 0;
  int fails = 0;

  localparam int K_PAD = 0, K_XOR = 1, K_RND = 2, K_SQ = 3;
  typedef struct {
    int          kind;
    logic [31:0] w;
    int          r;
  } ev_t;
  ev_t sched[$];

  function automatic logic [43:0] mk(logic rdy, logic bv, logic [31:0] bdat, logic ab, logic re,
                                     int rn, logic ov, logic cl, logic bz);
    return {rdy, bv, bdat, ab, re, 5'(rn), ov, cl, bz};
  endfunction

  task automatic chk(input string tag, input logic [43:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push_perm(int n);
    ev_t e;
    e.kind = K_XOR; e.w = '0; e.r = 0;
    sched.push_back(e);
    for (int r = 0; r < n; r++) begin
      e.kind = K_RND; e.r = r;
      sched.push_back(e);
    end
  endfunction

  // pad10*1 over positions start..R-1: low bit on the first pad word, top bit on the block's last word
  function automatic void push_pad(int start, int rate);
    ev_t e;
    for (int p = start; p < rate; p++) begin
      e.kind = K_PAD; e.r = 0;
      e.w = ((p == start) ? 32'h0000_0001 : 32'h0) | ((p == rate - 1) ? 32'h8000_0000 : 32'h0);
      sched.push_back(e);
    end
  endfunction

  task automatic run_msg(input string tag, input bit use_d, input int len, input int gap_pct,
                         input bit vbusy, input int sq_wait, input int abort_rnd);
    int rate = use_d ? 34 : 4;
    int nr   = use_d ? 24 : 3;
    logic [31:0] msg[$];
    int widx = 0, wpos = 0, sqc = 0, cyc = 0;
    bit done = 0, aborted = 0;
    ev_t ev;
    logic [43:0] exp;
    sel = use_d;
    sched.delete();
    for (int i = 0; i < len; i++) msg.push_back($urandom);
    while (!done && !aborted && cyc < 4000) begin
      if (sched.size() > 0) begin
        ev = sched[0];
        drv_valid  = vbusy ? ($urandom_range(1) == 1) : 1'b0;
        drv_data   = $urandom;
        drv_last   = ($urandom_range(1) == 1);
        drv_oready = ($urandom_range(1) == 1);
        case (ev.kind)
          K_PAD: begin exp = mk(0, 1, ev.w, 0, 0, 0, 0, 0, 1); void'(sched.pop_front()); end
          K_XOR: begin exp = mk(0, 0, '0, 1, 0, 0, 0, 0, 1); void'(sched.pop_front()); end
          K_RND: begin exp = mk(0, 0, '0, 0, 1, ev.r, 0, 0, 1); void'(sched.pop_front()); end
          default: begin
            drv_oready = (sqc >= sq_wait);
            exp = mk(0, 0, '0, 0, 0, 0, 1, drv_oready, 1);
            sqc++;
            if (drv_oready) begin void'(sched.pop_front()); done = 1; end
          end
        endcase
        #2 chk(tag, exp);
        if (abort_rnd >= 0 && ev.kind == K_RND && ev.r == abort_rnd) begin
          reset = 1'b0;
          drv_valid = 1'b1;
          #1 chk({tag, "_rst_now"}, '0);
          @(negedge clock);
          #2 chk({tag, "_rst_held"}, '0);
          reset = 1'b1;
          drv_valid = 1'b0;
          drv_oready = 1'b0;
          #1 chk({tag, "_rst_release"}, mk(1, 0, '0, 0, 0, 0, 0, 0, 0));
          sched.delete();
          aborted = 1;
        end
      end else begin
        drv_valid  = ($urandom_range(99) >= gap_pct);
        drv_data   = msg[widx];
        drv_last   = (widx == len - 1);
        drv_oready = ($urandom_range(1) == 1);
        exp = mk(1, drv_valid, drv_valid ? drv_data : 32'h0, 0, 0, 0, 0, 0, wpos != 0);
        #2 chk(tag, exp);
        if (drv_valid) begin
          widx++;
          wpos++;
          if (wpos == rate) begin
            wpos = 0;
            push_perm(nr);
            if (drv_last) begin
              push_pad(0, rate);
              push_perm(nr);
              sched.push_back('{K_SQ, 32'h0, 0});
            end
          end else if (drv_last) begin
            push_pad(wpos, rate);
            wpos = 0;
            push_perm(nr);
            sched.push_back('{K_SQ, 32'h0, 0});
          end
        end
      end
      @(negedge clock);
      cyc++;
    end
    if (!aborted) begin
      tests++;
      assert (done) else begin
        fails++;
        $error("FAIL %s_timeout observed=not_done expected=done", tag);
      end
      drv_valid  = 1'b0;
      drv_oready = 1'b0;
      #2 chk({tag, "_idle"}, mk(1, 0, '0, 0, 0, 0, 0, 0, 0));
      @(negedge clock);
    end
  endtask

  initial begin
    reset      = 1'b0;
    drv_valid  = 1'b1;
    drv_last   = 1'b1;
    drv_oready = 1'b1;
    drv_data   = $urandom;
    repeat (2) @(negedge clock);
    sel = 1'b0;
    #2 chk("reset_small", '0);
    sel = 1'b1;
    #1 chk("reset_dflt", '0);
    @(negedge clock);
    reset = 1'b1;
    drv_valid = 1'b0;
    drv_oready = 1'b0;
    sel = 1'b0;
    #2 chk("idle_small", mk(1, 0, '0, 0, 0, 0, 0, 0, 0));
    sel = 1'b1;
    #1 chk("idle_dflt", mk(1, 0, '0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);

    run_msg("two_words",    0, 2, 0, 0, 0, -1);
    run_msg("three_words",  0, 3, 0, 0, 0, -1);
    run_msg("full_block",   0, 4, 0, 0, 0, -1);
    run_msg("backpressure", 0, 5, 0, 1, 5, -1);
    run_msg("mid_reset",    0, 6, 0, 1, 0, 1);
    run_msg("after_reset",  0, 1, 0, 0, 0, -1);
    run_msg("dflt_34",      1, 34, 30, 0, 2, -1);
    for (int i = 0; i < 6; i++)
      run_msg("rand_small", 0, $urandom_range(13, 1), 40, ($urandom_range(1) == 1), $urandom_range(3), -1);
    for (int i = 0; i < 3; i++)
      run_msg("rand_dflt", 1, $urandom_range(80, 1), 25, ($urandom_range(1) == 1), $urandom_range(3), -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
